spi_cmd_sequencer: RTL

- Command-level controller between the SPI byte slave and the rest of the system.
- Parses host command frames (framed by spi_cs_n) and sequences SDRAM ROM-image/zero-fill writes, key-matrix writes and CPU reset control.
- Supplies the response byte that the SPI slave shifts out on the next byte.
- Sits between the SPI byte engine and the SDRAM arbiter write port in the top entity.

---
 rtl/spi_cmd_sequencer_pkg.sv | 28 ++
 rtl/spi_cmd_sequencer_if.sv | 24 ++
 rtl/spi_cmd_sequencer.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/spi_cmd_sequencer_pkg.sv
// rtl/spi_cmd_sequencer_pkg.sv - command codes, state encoding and constants for the SPI command sequencer
package spi_cmd_pkg;

  localparam logic [7:0] IDLE_RESP = 8'hA5;
  localparam int OFFSET_W = 14;
  localparam int BANK_W   = 9;
  localparam int ADDR_W   = BANK_W + OFFSET_W;

  localparam logic [7:0] CMD_PING   = 8'h00;
  localparam logic [7:0] CMD_START  = 8'h02;
  localparam logic [7:0] CMD_KEY    = 8'h03;
  localparam logic [7:0] CMD_WRITE  = 8'h04;
  localparam logic [7:0] CMD_STATUS = 8'h05;
  localparam logic [7:0] CMD_HOLD   = 8'h06;
  localparam logic [7:0] CMD_BANKHI = 8'h07;

  typedef enum logic [2:0] {
    ST_CMD,
    ST_IGNORE,
    ST_KEY_Y,
    ST_KEY_X,
    ST_BANK,
    ST_BANKHI,
    ST_DATA,
    ST_STATUS
  } state_t;

endpackage

// File: rtl/spi_cmd_sequencer_if.sv
// rtl/spi_cmd_sequencer_if.sv - SDRAM arbiter write port between the sequencer (master) and arbiter (slave)
interface spi_cmd_sequencer_if;
  import spi_cmd_pkg::*;

  logic              mem_req;
  logic              mem_ack;
  logic [ADDR_W-1:0] mem_address;
  logic [7:0]        mem_wdata;

  modport master (
    output mem_req,
    output mem_address,
    output mem_wdata,
    input  mem_ack
  );

  modport slave (
    input  mem_req,
    input  mem_address,
    input  mem_wdata,
    output mem_ack
  );

endinterface

// File: rtl/spi_cmd_sequencer.sv
// rtl/spi_cmd_sequencer.sv - parses SPI command frames into SDRAM writes, key-matrix writes and CPU reset control
module spi_cmd_sequencer
  import spi_cmd_pkg::*;
(
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        spi_cs_n,
  input  logic                        rx_valid,
  input  logic [7:0]                  rx_data,
  output logic [7:0]                  tx_data,
  input  logic                        sdram_busy,
  spi_cmd_sequencer_if.master         mem,
  output logic                        key_we,
  output logic [3:0]                  key_y,
  output logic [7:0]                  key_x,
  output logic                        cpu_reset
);

  state_t            state, state_n;
  logic [7:0]        tx_r, tx_n;
  logic              req_r, req_n;
  logic [ADDR_W-1:0] addr_r, addr_n;
  logic [7:0]        wdata_r, wdata_n;
  logic              key_we_r, key_we_n;
  logic [3:0]        key_y_r, key_y_n;
  logic [7:0]        key_x_r, key_x_n;
  logic              cpu_r, cpu_n;
  logic              bank_hi_r, bank_hi_n;
  logic              overrun_r, overrun_n;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_CMD;
      tx_r      <= IDLE_RESP;
      req_r     <= 1'b0;
      addr_r    <= '0;
      wdata_r   <= '0;
      key_we_r  <= 1'b0;
      key_y_r   <= '0;
      key_x_r   <= '0;
      cpu_r     <= 1'b1;
      bank_hi_r <= 1'b0;
      overrun_r <= 1'b0;
    end else begin
      state     <= state_n;
      tx_r      <= tx_n;
      req_r     <= req_n;
      addr_r    <= addr_n;
      wdata_r   <= wdata_n;
      key_we_r  <= key_we_n;
      key_y_r   <= key_y_n;
      key_x_r   <= key_x_n;
      cpu_r     <= cpu_n;
      bank_hi_r <= bank_hi_n;
      overrun_r <= overrun_n;
    end
  end

  always_comb begin
    state_n   = state;
    tx_n      = tx_r;
    req_n     = req_r;
    addr_n    = addr_r;
    wdata_n   = wdata_r;
    key_we_n  = 1'b0;
    key_y_n   = key_y_r;
    key_x_n   = key_x_r;
    cpu_n     = cpu_r;
    bank_hi_n = bank_hi_r;
    overrun_n = overrun_r;

    // Completion runs regardless of framing; the offset wraps inside its bank.
    if (req_r && mem.mem_ack) begin
      req_n                  = 1'b0;
      addr_n[OFFSET_W-1:0]   = addr_r[OFFSET_W-1:0] + OFFSET_W'(1);
    end

    if (spi_cs_n) begin
      state_n = ST_CMD;
      tx_n    = IDLE_RESP;
    end else if (rx_valid) begin
      unique case (state)
        ST_CMD: begin
          state_n = ST_IGNORE;
          case (rx_data)
            CMD_PING:   state_n = ST_CMD;
            CMD_START:  cpu_n = 1'b0;
            CMD_KEY:    state_n = ST_KEY_Y;
            CMD_WRITE:  state_n = ST_BANK;
            CMD_STATUS: begin
              tx_n      = {6'b0, overrun_r, sdram_busy};
              overrun_n = 1'b0;
              state_n   = ST_STATUS;
            end
            CMD_HOLD:   cpu_n = 1'b1;
            CMD_BANKHI: state_n = ST_BANKHI;
            default: ;
          endcase
        end
        ST_KEY_Y: begin
          key_y_n = rx_data[3:0];
          state_n = ST_KEY_X;
        end
        ST_KEY_X: begin
          key_x_n  = rx_data;
          key_we_n = 1'b1;
          state_n  = ST_IGNORE;
        end
        ST_BANKHI: begin
          bank_hi_n = rx_data[0];
          state_n   = ST_IGNORE;
        end
        ST_BANK: begin
          addr_n  = {bank_hi_r, rx_data, {OFFSET_W{1'b0}}};
          state_n = ST_DATA;
        end
        ST_DATA: begin
          // A byte landing while the previous write is outstanding is lost.
          if (req_r) begin
            overrun_n = 1'b1;
          end else begin
            wdata_n = rx_data;
            req_n   = 1'b1;
          end
        end
        ST_STATUS: begin
          tx_n    = IDLE_RESP;
          state_n = ST_IGNORE;
        end
        ST_IGNORE: ;
      endcase
    end
  end

  assign tx_data         = tx_r;
  assign mem.mem_req     = req_r;
  assign mem.mem_address = addr_r;
  assign mem.mem_wdata   = wdata_r;
  assign key_we          = key_we_r;
  assign key_y           = key_y_r;
  assign key_x           = key_x_r;
  assign cpu_reset       = cpu_r;

endmodule
